// File: rtl/subsistema_multiplicacion.sv
// Sequential shift-and-add unsigned multiplier: ANCHO iterations per product,
// with registered busy/done status and a result held for the display stage.
module subsistema_multiplicacion #(
  parameter int unsigned ANCHO = 4
) (
  input  logic               reloj,
  input  logic               reinicio,
  input  logic               iniciar,
  input  logic [ANCHO-1:0]   operandoA,
  input  logic [ANCHO-1:0]   operandoB,
  output logic [2*ANCHO-1:0] producto,
  output logic               ocupado,
  output logic               listo
);

  localparam int unsigned    CW    = $clog2(ANCHO + 1);
  localparam logic [CW-1:0]  C_ULT = CW'(ANCHO - 1);

  typedef enum logic [1:0] {
    INACTIVO,
    CALCULO,
    LISTO
  } estado_t;

  estado_t            r_estado;
  logic [ANCHO-1:0]   r_m;
  logic [ANCHO-1:0]   r_q;
  logic [ANCHO:0]     r_acum;
  logic [CW-1:0]      r_cont;
  logic [2*ANCHO-1:0] r_producto;
  logic               r_ocupado;
  logic               r_listo;
  logic [ANCHO:0]     w_suma;

  // Partial sum kept ANCHO+1 wide so the carry shifts into the product.
  always_comb begin
    w_suma = r_acum;
    if (r_q[0]) begin
      w_suma = {1'b0, r_acum[ANCHO-1:0]} + {1'b0, r_m};
    end
  end

  always_ff @(posedge reloj) begin
    if (reinicio) begin
      r_estado   <= INACTIVO;
      r_m        <= '0;
      r_q        <= '0;
      r_acum     <= '0;
      r_cont     <= '0;
      r_producto <= '0;
      r_ocupado  <= 1'b0;
      r_listo    <= 1'b0;
    end else begin
      unique case (r_estado)
        INACTIVO: begin
          r_listo   <= 1'b0;
          r_ocupado <= iniciar;
          if (iniciar) begin
            r_m      <= operandoA;
            r_q      <= operandoB;
            r_acum   <= '0;
            r_cont   <= '0;
            r_estado <= CALCULO;
          end
        end
        CALCULO: begin
          r_acum <= {1'b0, w_suma[ANCHO:1]};
          r_q    <= {w_suma[0], r_q[ANCHO-1:1]};
          r_cont <= r_cont + 1'b1;
          if (r_cont == C_ULT) begin
            r_estado <= LISTO;
          end
        end
        LISTO: begin
          // ocupado stays high through this edge; it drops back in INACTIVO.
          r_producto <= {r_acum[ANCHO-1:0], r_q};
          r_listo    <= 1'b1;
          r_estado   <= INACTIVO;
        end
        default: begin
          r_estado <= INACTIVO;
        end
      endcase
    end
  end

  assign producto = r_producto;
  assign ocupado  = r_ocupado;
  assign listo    = r_listo;

endmodule

// File: tb/tb_subsistema_multiplicacion.sv
// Self-checking bench for subsistema_multiplicacion: each scenario task drives
// stimulus and compares against integer products and the documented timing.
module tb_subsistema_multiplicacion;

  localparam int unsigned W   = 4;
  localparam int unsigned LAT = W + 1;
  localparam int unsigned PER = W + 2;

  logic             reloj;
  logic             reinicio;
  logic             iniciar;
  logic [W-1:0]     operandoA;
  logic [W-1:0]     operandoB;
  logic [2*W-1:0]   producto;
  logic             ocupado;
  logic             listo;

  int unsigned      n_vec;
  int unsigned      n_err;
  logic [2*W-1:0]   exp_prod;

  subsistema_multiplicacion #(.ANCHO(W)) dut (
    .reloj     (reloj),
    .reinicio  (reinicio),
    .iniciar   (iniciar),
    .operandoA (operandoA),
    .operandoB (operandoB),
    .producto  (producto),
    .ocupado   (ocupado),
    .listo     (listo)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic tick();
    @(posedge reloj);
    #1;
  endtask

  // One full multiplication from a one-cycle strobe, checking latency, status and result.
  task automatic run_mult(input int unsigned a, input int unsigned b, input string tag);
    int unsigned lat;
    int unsigned busy;
    logic [2*W-1:0] want;
    want      = (2*W)'(a * b);
    operandoA = W'(a);
    operandoB = W'(b);
    iniciar   = 1'b1;
    tick();
    iniciar   = 1'b0;
    operandoA = W'($urandom);
    operandoB = W'($urandom);
    lat  = 0;
    busy = 0;
    while (!listo && lat < 4 * W) begin
      if (ocupado) busy++;
      if (producto !== exp_prod) begin
        n_err++;
        $display("FAIL %s hold: producto=%0d expected=%0d", tag, producto, exp_prod);
      end
      operandoA = W'($urandom);
      operandoB = W'($urandom);
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== LAT) begin
      n_err++;
      $display("FAIL %s latency: got=%0d expected=%0d", tag, lat, LAT);
    end
    n_vec++;
    if (producto !== want) begin
      n_err++;
      $display("FAIL %s producto: got=%0d expected=%0d", tag, producto, want);
    end
    n_vec++;
    if (ocupado !== 1'b1) begin
      n_err++;
      $display("FAIL %s ocupado_at_listo: got=%b expected=1", tag, ocupado);
    end
    exp_prod = want;
    tick();
    n_vec++;
    if (listo !== 1'b0 || ocupado !== 1'b0 || (busy + 1) !== PER) begin
      n_err++;
      $display("FAIL %s after: listo=%b ocupado=%b busy_cycles=%0d expected 0/0/%0d",
               tag, listo, ocupado, busy + 1, PER);
    end
  endtask

  task automatic test_reset();
    reinicio  = 1'b1;
    iniciar   = 1'b0;
    operandoA = '0;
    operandoB = '0;
    tick();
    tick();
    n_vec++;
    if (producto !== '0 || ocupado !== 1'b0 || listo !== 1'b0) begin
      n_err++;
      $display("FAIL reset: producto=%0d ocupado=%b listo=%b expected 0/0/0", producto, ocupado, listo);
    end
    // reset and start on the same edge: the start must be discarded
    iniciar   = 1'b1;
    operandoA = W'(7);
    operandoB = W'(7);
    tick();
    reinicio = 1'b0;
    iniciar  = 1'b0;
    for (int i = 0; i < 2 * PER; i++) begin
      n_vec++;
      if (ocupado !== 1'b0 || listo !== 1'b0 || producto !== '0) begin
        n_err++;
        $display("FAIL reset_vs_start: ocupado=%b listo=%b producto=%0d expected 0/0/0",
                 ocupado, listo, producto);
      end
      tick();
    end
    exp_prod = '0;
  endtask

  task automatic test_basic();
    run_mult(7, 3, "a7b3");
    run_mult(15, 15, "a15b15");
    run_mult(0, 9, "a0b9");
    run_mult(9, 0, "a9b0");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_mult($urandom_range(0, (1 << W) - 1), $urandom_range(0, (1 << W) - 1), "random");
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 8; i++) begin
      operandoA = W'($urandom);
      operandoB = W'($urandom);
      tick();
      n_vec++;
      if (producto !== exp_prod || ocupado !== 1'b0 || listo !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold: producto=%0d ocupado=%b listo=%b expected %0d/0/0",
                 producto, ocupado, listo, exp_prod);
      end
    end
  endtask

  task automatic test_ignore_restart();
    int unsigned lat;
    int unsigned extra;
    operandoA = W'(5);
    operandoB = W'(6);
    iniciar   = 1'b1;
    tick();
    iniciar = 1'b0;
    lat     = 0;
    tick();
    lat++;
    operandoA = W'(2);
    operandoB = W'(2);
    iniciar   = 1'b1;
    tick();
    lat++;
    iniciar = 1'b0;
    while (!listo && lat < 4 * W) begin
      tick();
      lat++;
    end
    n_vec++;
    if (lat !== LAT || producto !== (2*W)'(30)) begin
      n_err++;
      $display("FAIL ignore_restart: latency=%0d producto=%0d expected %0d/30", lat, producto, LAT);
    end
    exp_prod = (2*W)'(30);
    extra = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick();
      if (listo) extra++;
    end
    n_vec++;
    if (extra !== 0 || producto !== exp_prod || ocupado !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_no_second: extra_listo=%0d producto=%0d ocupado=%b expected 0/%0d/0",
               extra, producto, ocupado, exp_prod);
    end
  endtask

  task automatic test_abort();
    int unsigned extra;
    operandoA = W'(12);
    operandoB = W'(11);
    iniciar   = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
    tick();
    reinicio = 1'b1;
    tick();
    reinicio = 1'b0;
    n_vec++;
    if (ocupado !== 1'b0 || listo !== 1'b0 || producto !== '0) begin
      n_err++;
      $display("FAIL abort: ocupado=%b listo=%b producto=%0d expected 0/0/0", ocupado, listo, producto);
    end
    exp_prod = '0;
    extra    = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      tick();
      if (listo || ocupado) extra++;
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++;
      $display("FAIL abort_quiet: active_cycles=%0d expected 0", extra);
    end
    run_mult(3, 4, "after_abort");
  endtask

  task automatic test_back_to_back();
    int unsigned t;
    int unsigned last_t;
    int unsigned n_res;
    operandoA = W'(1);
    operandoB = W'(15);
    iniciar   = 1'b1;
    tick();
    t      = 0;
    last_t = 0;
    n_res  = 0;
    while (n_res < 4 && t < 8 * PER) begin
      tick();
      t++;
      if (listo) begin
        n_vec++;
        if ((n_res == 0 && t !== LAT) || (n_res != 0 && (t - last_t) !== PER) || producto !== (2*W)'(15)) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: cycle=%0d prev=%0d producto=%0d expected spacing %0d producto 15",
                   n_res, t, last_t, producto, PER);
        end
        last_t = t;
        n_res++;
      end
    end
    n_vec++;
    if (n_res !== 4) begin
      n_err++;
      $display("FAIL back_to_back_count: results=%0d expected 4", n_res);
    end
    iniciar  = 1'b0;
    exp_prod = (2*W)'(15);
    t = 0;
    while (ocupado && t < 2 * PER) begin
      tick();
      t++;
    end
    n_vec++;
    if (ocupado !== 1'b0 || producto !== exp_prod) begin
      n_err++;
      $display("FAIL back_to_back_drain: ocupado=%b producto=%0d expected 0/%0d", ocupado, producto, exp_prod);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    exp_prod = '0;
    reinicio = 1'b1;
    iniciar  = 1'b0;
    operandoA = '0;
    operandoB = '0;
    #1;
    test_reset();
    test_basic();
    test_hold();
    test_ignore_restart();
    test_abort();
    test_back_to_back();
    test_random();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/subsistema_multiplicacion.md
# subsistema_multiplicacion

Sequential shift-and-add multiplier stage that sits directly downstream of the operand-reading subsystem. It accepts a pair of unsigned operands with a single-cycle start strobe and computes their full-width product over ANCHO iterations. It holds the result stable for the display stage, and provides busy/done status for the board LEDs.

## Interface

- ANCHO, default 4: operand width in bits; product width is 2*ANCHO.
- reloj  input  1: single system clock; all state updates on rising edge.
- reinicio  input  1: reset, synchronous, active-high.
- iniciar  input  1: start strobe from the reading stage; sampled each rising edge.
- operandoA  input  ANCHO: multiplicand, unsigned; sampled only when a start is accepted.
- operandoB  input  ANCHO: multiplier, unsigned; sampled only when a start is accepted.
- producto  output  2*ANCHO: registered result of the last completed multiplication.
- ocupado  output  1: high while a multiplication is in progress, including the LISTO cycle.
- listo  output  1: one-cycle pulse when producto updates.

## Operation

- FSM states: INACTIVO, CALCULO, LISTO.
- Internal registers:
  - M (ANCHO): multiplicand copy.
  - acumulador (ANCHO+1, includes carry bit).
  - Q (ANCHO): multiplier / low half of the product.
  - contador (ceil(log2(ANCHO+1)) bits).
- INACTIVO with iniciar=1 (start accepted):
  - M<=operandoA, Q<=operandoB, acumulador<=0, contador<=0.
  - Next state CALCULO.
- INACTIVO with iniciar=0: hold state.
- CALCULO, each cycle:
  - If Q[0]=1, the sum is acumulador[ANCHO-1:0]+M, computed ANCHO+1 wide so the carry is kept; otherwise the sum is acumulador unchanged.
  - Shift {sum, Q} right by one; the vacated MSB is 0.
  - contador<=contador+1.
  - When contador reaches ANCHO-1 in this cycle, next state is LISTO.
- LISTO:
  - producto<={acumulador[ANCHO-1:0], Q}.
  - listo=1 for exactly this cycle.
  - Next state INACTIVO.
- Width rules:
  - Unsigned arithmetic throughout.
  - Overflow is impossible: (2^ANCHO-1)^2 fits in 2*ANCHO bits.
  - The acumulador carry bit is always 0 after the final shift.
- iniciar while ocupado=1 (CALCULO or LISTO) is ignored. It is not queued, and operands are not resampled.
- Operand inputs changing during CALCULO have no effect.
- Reset values, applied on any edge with reinicio=1 regardless of state (aborts any multiplication in progress):
  - producto=0, ocupado=0, listo=0.
  - FSM=INACTIVO; M, acumulador, Q, contador all 0.
- reinicio and iniciar high on the same edge: reset wins; the start is discarded.
- producto holds its value between multiplications. It changes only in LISTO or on reset.

## Timing

- ocupado and listo are decoded from the registered state; no combinational path from inputs to outputs.
- Start accepted at edge k:
  - ocupado=1 from edge k.
  - CALCULO occupies edges k+1 through k+ANCHO.
  - LISTO is entered after edge k+ANCHO; listo=1 and the new producto are visible after edge k+ANCHO+1.
- Latency from accepted start to listo is ANCHO+1 cycles; 5 cycles for ANCHO=4.
- ocupado falls after edge k+ANCHO+2, which returns the FSM to INACTIVO.
- Earliest next start is accepted at edge k+ANCHO+2 (FSM in INACTIVO).
- Throughput: one multiplication per ANCHO+2 cycles with back-to-back strobes.
- The iniciar strobe may be held high longer than one cycle. It is re-accepted only once the FSM is back in INACTIVO, so a held level restarts the multiplication with the current operands.

## Test plan

- Reset, then iniciar with A=7, B=3 -> listo pulses exactly once, 5 cycles after acceptance; producto=8'd21; ocupado high for 6 cycles.
- A=15, B=15 -> producto=8'hE1 (225). Checks the carry path into the acumulador MSB.
- A=0, B=9, then A=9, B=0 -> producto=0 both times; listo still pulses with 5-cycle latency.
- Start A=5, B=6; re-pulse iniciar with A=2, B=2 during CALCULO -> single listo, producto=30; no second result.
- Start A=12, B=11 (result 132); assert reinicio at the third CALCULO cycle -> next cycle ocupado=0, listo=0, producto=0; no listo follows. A new start A=3, B=4 then yields producto=12.
- Back-to-back: iniciar held high with A=1, B=15 -> producto=15 each time; listo pulses every 6 cycles.
